// File: rtl/elevator_ctrl.sv
// Two-limit elevator controller: one-hot FSM with travel timeout,
// dwell hold-off at the limits and a sticky fault cleared by Halt.
module elevator_ctrl #(
  parameter int DWELL      = 3,
  parameter int MAX_TRAVEL = 16
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Go_Up,
  input  logic       Go_Down,
  input  logic       Halt,
  input  logic       Top_Limit_Hit,
  input  logic       Bottom_Limit_Hit,
  output logic [4:0] state,
  output logic       Motor_Up,
  output logic       Motor_Down,
  output logic       Fault
);

  localparam logic [4:0] IDLE   = 5'b00001;
  localparam logic [4:0] UP     = 5'b00010;
  localparam logic [4:0] DOWN   = 5'b00100;
  localparam logic [4:0] TOP    = 5'b01000;
  localparam logic [4:0] BOTTOM = 5'b10000;

  localparam int TW = $clog2(MAX_TRAVEL) + 1;
  localparam int DW = $clog2(DWELL) + 1;

  localparam logic [TW-1:0] T_LAST = TW'(MAX_TRAVEL - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [DW-1:0] D_DONE = DW'(DWELL);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  logic [4:0]    state_nx;
  logic          fault_nx;
  logic [TW-1:0] travel_q;
  logic [TW-1:0] travel_nx;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_nx;

  logic go_up;
  logic go_dn;
  logic moving;
  logic expired;
  logic dwell_done;

  // A command counts only when unambiguous and no fault is latched.
  assign go_up      = Go_Up & ~Go_Down & ~Fault;
  assign go_dn      = Go_Down & ~Go_Up & ~Fault;
  assign moving     = state[1] | state[2];
  assign expired    = moving && (travel_q == T_LAST);
  assign dwell_done = (dwell_q == D_DONE);

  always_comb begin
    state_nx  = state;
    fault_nx  = Fault;
    travel_nx = '0;
    dwell_nx  = '0;
    if (Halt) begin
      state_nx = IDLE;
      fault_nx = 1'b0;
    end else if (Top_Limit_Hit && Bottom_Limit_Hit) begin
      state_nx = IDLE;
      fault_nx = 1'b1;
    end else if (Top_Limit_Hit) begin
      state_nx = TOP;
    end else if (Bottom_Limit_Hit) begin
      state_nx = BOTTOM;
    end else if (expired) begin
      state_nx = IDLE;
      fault_nx = 1'b1;
    end else begin
      unique case (1'b1)
        state[0]: begin
          if (go_up) begin
            state_nx = UP;
          end else if (go_dn) begin
            state_nx = DOWN;
          end
        end
        state[1], state[2]: begin
          travel_nx = travel_q + T_ONE;
        end
        state[3]: begin
          if (dwell_done && go_dn) begin
            state_nx = DOWN;
          end else begin
            dwell_nx = dwell_done ? dwell_q : dwell_q + D_ONE;
          end
        end
        state[4]: begin
          if (dwell_done && go_up) begin
            state_nx = UP;
          end else begin
            dwell_nx = dwell_done ? dwell_q : dwell_q + D_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Fault    <= 1'b0;
      travel_q <= '0;
      dwell_q  <= '0;
    end else begin
      state    <= state_nx;
      Fault    <= fault_nx;
      travel_q <= travel_nx;
      dwell_q  <= dwell_nx;
    end
  end

  assign Motor_Up   = (state == UP);
  assign Motor_Down = (state == DOWN);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios plus random stimulus
// compared against a cycle-age reference model of the controller.
module tb_elevator_ctrl;

  localparam int DWELL      = 3;
  localparam int MAX_TRAVEL = 16;

  localparam int M_IDLE   = 0;
  localparam int M_UP     = 1;
  localparam int M_DOWN   = 2;
  localparam int M_TOP    = 3;
  localparam int M_BOTTOM = 4;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Go_Up = 1'b0;
  logic       Go_Down = 1'b0;
  logic       Halt = 1'b0;
  logic       Top_Limit_Hit = 1'b0;
  logic       Bottom_Limit_Hit = 1'b0;
  logic [4:0] state;
  logic       Motor_Up;
  logic       Motor_Down;
  logic       Fault;

  int total = 0;
  int bad   = 0;

  int m_mode  = M_IDLE;
  int m_age   = 0;
  bit m_fault = 1'b0;

  elevator_ctrl #(
    .DWELL(DWELL),
    .MAX_TRAVEL(MAX_TRAVEL)
  ) dut (
    .CLK(CLK),
    .Reset_n(Reset_n),
    .Go_Up(Go_Up),
    .Go_Down(Go_Down),
    .Halt(Halt),
    .Top_Limit_Hit(Top_Limit_Hit),
    .Bottom_Limit_Hit(Bottom_Limit_Hit),
    .state(state),
    .Motor_Up(Motor_Up),
    .Motor_Down(Motor_Down),
    .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // m_age counts edges spent in the current state since entry
  // (or since the last limit assertion at a landing).
  task automatic model_edge(input bit rst, input bit up,
                            input bit dn, input bit hlt,
                            input bit top, input bit bot);
    int nxt;
    bit cu;
    bit cd;
    if (!rst) begin
      m_mode = M_IDLE; m_fault = 0; m_age = 0;
    end else if (hlt) begin
      m_mode = M_IDLE; m_fault = 0; m_age = 0;
    end else if (top && bot) begin
      m_mode = M_IDLE; m_fault = 1; m_age = 0;
    end else if (top) begin
      m_mode = M_TOP; m_age = 0;
    end else if (bot) begin
      m_mode = M_BOTTOM; m_age = 0;
    end else if ((m_mode == M_UP || m_mode == M_DOWN)
                 && m_age == MAX_TRAVEL - 1) begin
      m_mode = M_IDLE; m_fault = 1; m_age = 0;
    end else begin
      cu  = up && !dn && !m_fault;
      cd  = dn && !up && !m_fault;
      nxt = m_mode;
      if (m_mode == M_IDLE && cu) nxt = M_UP;
      if (m_mode == M_IDLE && cd) nxt = M_DOWN;
      if (m_mode == M_TOP && cd && m_age >= DWELL) nxt = M_DOWN;
      if (m_mode == M_BOTTOM && cu && m_age >= DWELL) nxt = M_UP;
      if (nxt != m_mode) begin
        m_mode = nxt; m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit up, input bit dn,
                      input bit hlt, input bit top, input bit bot);
    logic [4:0] es;
    @(negedge CLK);
    Reset_n = rst; Go_Up = up; Go_Down = dn;
    Halt = hlt; Top_Limit_Hit = top; Bottom_Limit_Hit = bot;
    @(posedge CLK);
    model_edge(rst, up, dn, hlt, top, bot);
    #1;
    es = 5'b00001 << m_mode;
    chk("state", state, es);
    chk("fault", Fault, m_fault);
    chk("motor_up", Motor_Up, m_mode == M_UP);
    chk("motor_dn", Motor_Down, m_mode == M_DOWN);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("rst_state", state, 5'b00001);
    chk("rst_fault", Fault, 1'b0);

    step(1, 1, 0, 0, 0, 0);
    chk("go_up", state, 5'b00010);
    chk("go_up_motor", Motor_Up, 1'b1);
    step(1, 0, 0, 0, 1, 0);
    chk("top_hit", state, 5'b01000);
    chk("top_motor", Motor_Up, 1'b0);
    step(1, 0, 1, 0, 0, 0);
    chk("dwell_ign", state, 5'b01000);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("dwell_last", state, 5'b01000);
    step(1, 0, 1, 0, 0, 0);
    chk("dwell_done", state, 5'b00100);
    step(1, 0, 0, 0, 0, 1);
    chk("bottom_hit", state, 5'b10000);

    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < MAX_TRAVEL - 1; i++) step(1, 0, 0, 0, 0, 0);
    chk("pre_timeout", state, 5'b00010);
    step(1, 0, 0, 0, 0, 0);
    chk("timeout_st", state, 5'b00001);
    chk("timeout_flt", Fault, 1'b1);
    step(1, 1, 0, 0, 0, 0);
    chk("fault_ign", state, 5'b00001);
    step(1, 0, 0, 1, 0, 0);
    chk("halt_clr", Fault, 1'b0);
    step(1, 1, 0, 0, 0, 0);
    chk("go_after", state, 5'b00010);

    step(1, 0, 1, 0, 0, 0);
    chk("no_reverse", state, 5'b00010);
    step(1, 0, 0, 1, 0, 0);
    chk("halt_up", state, 5'b00001);
    step(1, 1, 1, 0, 0, 0);
    chk("both_go", state, 5'b00001);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    chk("both_lim", state, 5'b00001);
    chk("both_lim_f", Fault, 1'b1);
    step(1, 0, 0, 1, 0, 0);

    step(1, 0, 1, 0, 0, 0);
    chk("go_down", state, 5'b00100);
    step(0, 0, 1, 0, 0, 0);
    chk("rst_mid", state, 5'b00001);
    chk("rst_mid_md", Motor_Down, 1'b0);
    step(1, 0, 0, 1, 1, 0);
    chk("halt_wins", state, 5'b00001);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("top_in_down", state, 5'b01000);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 24) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter DWELL, default 3: cycles held in TOP/BOTTOM before a new Go command is accepted.
REQ-002 Parameter MAX_TRAVEL, default 16: cycles allowed in UP/DOWN before travel-timeout fault.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  reset, synchronous, active-low.
REQ-005 Go_Up  input  1  request upward travel, level, sampled each rising edge.
REQ-006 Go_Down  input  1  request downward travel, level, sampled each rising edge.
REQ-007 Halt  input  1  stop request; also clears Fault.
REQ-008 Top_Limit_Hit  input  1  upper limit switch.
REQ-009 Bottom_Limit_Hit  input  1  lower limit switch.
REQ-010 state  output  5  one-hot FSM state, registered.
REQ-011 Motor_Up  output  1  drive upward; 1 exactly when state=UP.
REQ-012 Motor_Down  output  1  drive downward; 1 exactly when state=DOWN.
REQ-013 Fault  output  1  sticky fault flag, registered.

Function
REQ-014 Encodings SHALL be: IDLE=5'b00001, UP=5'b00010, DOWN=5'b00100, TOP=5'b01000, BOTTOM=5'b10000; no other value reachable.
REQ-015 Inputs sampled at edge k SHALL be reflected on state/Fault after edge k (one-cycle latency); Motor_Up/Motor_Down decoded from the state register, no input-to-output combinational path.
REQ-016 Per-edge priority SHALL be: Halt > both limits asserted > single limit > travel timeout > Go commands.
REQ-017 Halt=1: next state IDLE, Fault cleared to 0, travel and dwell counters cleared, from any state.
REQ-018 Top_Limit_Hit=1 and Bottom_Limit_Hit=1 together (Halt=0): next state IDLE, Fault set to 1.
REQ-019 Top_Limit_Hit=1 alone (Halt=0): next state TOP from any state; dwell counter loaded to 0.
REQ-020 Bottom_Limit_Hit=1 alone (Halt=0): next state BOTTOM from any state; dwell counter loaded to 0.
REQ-021 In UP/DOWN a travel counter SHALL increment each cycle from 0 on entry; when it reaches MAX_TRAVEL-1 with no limit/Halt, next state IDLE and Fault set to 1.
REQ-022 In TOP/BOTTOM a dwell counter SHALL increment each cycle, saturating at DWELL; Go commands ignored while count < DWELL.
REQ-023 Go_Up and Go_Down both 1: command ignored, state unchanged (counters still advance).
REQ-024 Go command acceptance (Fault=0, single command, no higher-priority event): IDLE+Go_Up->UP; IDLE+Go_Down->DOWN; TOP+Go_Down (dwell done)->DOWN; BOTTOM+Go_Up (dwell done)->UP.
REQ-025 Ignored commands, state unchanged: TOP+Go_Up, BOTTOM+Go_Down, UP+Go_Down, DOWN+Go_Up (direct reversal forbidden; Halt required), UP+Go_Up, DOWN+Go_Down.
REQ-026 While Fault=1 all Go commands SHALL be ignored; limit inputs still move state to TOP/BOTTOM; only Halt or reset clears Fault.
REQ-027 Travel counter SHALL reset to 0 on every entry into UP/DOWN; counter widths sized by $clog2 of parameter +1, no wrap-around.

Reset
REQ-028 Reset_n=0 at a rising edge: state=IDLE, Fault=0, Motor_Up=0, Motor_Down=0, both counters 0, overriding all other inputs including mid-travel.
REQ-029 Before the first reset edge, outputs are undefined; no asynchronous behaviour on Reset_n.

Verification
REQ-030 Reset, then Go_Up pulse -> state 00001 to 00010, Motor_Up=1 next edge; Top_Limit_Hit -> state 01000, Motor_Up=0.
REQ-031 In TOP, Go_Down asserted 1 cycle after arrival -> ignored (DWELL=3); held until dwell done -> state 00100; Bottom_Limit_Hit -> 10000.
REQ-032 Go_Up from IDLE, no limit for 16 cycles -> state 00001, Fault=1; subsequent Go_Up ignored; Halt pulse -> Fault=0; Go_Up then accepted.
REQ-033 In UP: Go_Down -> stays 00010; both Go_Up and Go_Down in IDLE -> stays 00001; both limits together -> 00001, Fault=1.
REQ-034 Halt during UP -> 00001 next edge; Reset_n=0 during DOWN with Go_Down=1 held -> 00001, Fault=0, Motor_Down=0.
REQ-035 Halt and Top_Limit_Hit same edge -> 00001 (Halt wins); Top_Limit_Hit during DOWN -> 01000.
